// File: rtl/rot_operand_tx.sv
// rot_operand_tx: rotary-shaft operand transmitter for the add/sub unit.
// Sends a, b, op as four nibbles on y, each followed by one quadrature detent.
module rot_operand_tx #(
    parameter int PHASE_CYCLES = 4,
    parameter int SETUP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] a,
    input  logic [6:0] b,
    input  logic       op,
    input  logic       dir,
    output logic [3:0] y,
    output logic       rota,
    output logic       rotb,
    output logic       busy,
    output logic       done,
    output logic [1:0] nib_idx
);

    localparam int MAXC = (PHASE_CYCLES > SETUP_CYCLES) ?
                          PHASE_CYCLES : SETUP_CYCLES;
    localparam int TW = $clog2(MAXC + 1);
    localparam logic [TW-1:0] PH_LOAD = TW'(PHASE_CYCLES - 1);
    localparam logic [TW-1:0] SU_LOAD = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] ONE = TW'(1);

    typedef enum logic [2:0] {
        IDLE, SETUP, PH1, PH2, PH3, PH4, FIN
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [6:0]    a_q;
    logic [6:0]    b_q;
    logic          op_q;
    logic          dir_q;
    logic          tdone;

    assign tdone = (timer == '0);

    function automatic logic [3:0] nibble(input logic [1:0] idx);
        nibble = a_q[3:0];
        case (idx)
            2'd0: nibble = a_q[3:0];
            2'd1: nibble = {1'b0, a_q[6:4]};
            2'd2: nibble = b_q[3:0];
            2'd3: nibble = {op_q, b_q[6:4]};
            default: nibble = a_q[3:0];
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            dir_q   <= 1'b0;
            y       <= '0;
            rota    <= 1'b0;
            rotb    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            nib_idx <= '0;
        end else begin
            done <= 1'b0;
            if (!tdone) timer <= timer - ONE;
            case (state)
                // FIN accepts a held start so back-to-back frames
                // leave exactly one non-busy cycle between them.
                IDLE, FIN: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        dir_q   <= dir;
                        y       <= a[3:0];
                        nib_idx <= 2'd0;
                        busy    <= 1'b1;
                        timer   <= SU_LOAD;
                        state   <= SETUP;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SETUP: if (tdone) begin
                    state <= PH1;
                    timer <= PH_LOAD;
                    rota  <= ~dir_q;
                    rotb  <= dir_q;
                end
                PH1: if (tdone) begin
                    state <= PH2;
                    timer <= PH_LOAD;
                    rota  <= 1'b1;
                    rotb  <= 1'b1;
                end
                PH2: if (tdone) begin
                    state <= PH3;
                    timer <= PH_LOAD;
                    rota  <= dir_q;
                    rotb  <= ~dir_q;
                end
                PH3: if (tdone) begin
                    state <= PH4;
                    timer <= PH_LOAD;
                    rota  <= 1'b0;
                    rotb  <= 1'b0;
                end
                PH4: if (tdone) begin
                    if (nib_idx == 2'd3) begin
                        state   <= FIN;
                        timer   <= '0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        y       <= '0;
                        nib_idx <= 2'd0;
                    end else begin
                        state   <= SETUP;
                        timer   <= SU_LOAD;
                        nib_idx <= nib_idx + 2'd1;
                        y       <= nibble(nib_idx + 2'd1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
